// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline stage sequencer: FSM states,
// hazard-priority codes, and the helper that decides whether a state advances the pipe.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } state_t;

  typedef logic [2:0] hazard_t;

  localparam hazard_t HZ_NONE    = 3'd0;
  localparam hazard_t HZ_FETCH   = 3'd1;
  localparam hazard_t HZ_LOADUSE = 3'd2;
  localparam hazard_t HZ_BRANCH  = 3'd3;
  localparam hazard_t HZ_MEMWAIT = 3'd4;

  function automatic logic is_active(input state_t s);
    return (s == RUN) || (s == STEP);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Cycle / stall / flush performance counters; they count only while the
// sequencer is in RUN or STEP and wrap modulo 2^CNT_WIDTH.
module pipe_perf_cnt
  import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  state_t               state,
    input  hazard_t              hazard,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    function automatic logic [CNT_WIDTH-1:0] wrap_inc(input logic [CNT_WIDTH-1:0] v);
        return v + CNT_WIDTH'(1);
    endfunction

    logic active;
    logic stalled;
    logic flushed;

    assign active  = is_active(state);
    assign stalled = (hazard == HZ_MEMWAIT) || (hazard == HZ_LOADUSE) || (hazard == HZ_FETCH);
    assign flushed = (hazard == HZ_BRANCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (active) begin
            cycle_cnt <= wrap_inc(cycle_cnt);
            if (stalled) stall_cnt <= wrap_inc(stall_cnt);
            if (flushed) flush_cnt <= wrap_inc(flush_cnt);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage sequencer for the 5-stage MIPS pipeline: reset/run/halt/step FSM plus
// the hazard priority encoder that drives every stage's rst/en pair.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_en,
    input  logic                 step,
    input  logic                 reg_stall,
    input  logic                 branch_taken,
    input  logic                 inst_ack,
    input  logic                 mem_req,
    input  logic                 mem_ack,
    output logic                 if_rst,
    output logic                 id_rst,
    output logic                 exe_rst,
    output logic                 mem_rst,
    output logic                 wb_rst,
    output logic                 if_en,
    output logic                 id_en,
    output logic                 exe_en,
    output logic                 mem_en,
    output logic                 wb_en,
    output logic [1:0]           ctrl_state,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam logic [3:0] INIT_LAST = 4'(RST_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] init_cnt;
    logic       step_q;
    logic       step_rise;
    hazard_t    hazard;
    // Stage vectors ordered {if, id, exe, mem, wb}
    logic [4:0] rst_v;
    logic [4:0] en_v;

    assign step_rise = step & ~step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
            step_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            step_q   <= step;
            init_cnt <= (state == INIT) ? init_cnt + 4'd1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT: if (init_cnt == INIT_LAST) state_nxt = cpu_en ? RUN : HALT;
            RUN:  if (!cpu_en) state_nxt = HALT;
            HALT: if (step_rise) state_nxt = STEP;
            STEP: state_nxt = cpu_en ? RUN : HALT;
            default: state_nxt = INIT;
        endcase
    end

    // A held branch under a mem wait is deferred until the access completes
    always_comb begin
        if (mem_req && !mem_ack) hazard = HZ_MEMWAIT;
        else if (branch_taken)   hazard = HZ_BRANCH;
        else if (reg_stall)      hazard = HZ_LOADUSE;
        else if (!inst_ack)      hazard = HZ_FETCH;
        else                     hazard = HZ_NONE;
    end

    always_comb begin
        rst_v = 5'b11111;
        en_v  = 5'b00000;
        if (state == HALT) begin
            rst_v = 5'b00000;
        end else if (is_active(state)) begin
            unique case (hazard)
                HZ_MEMWAIT: begin rst_v = 5'b00000; en_v = 5'b00000; end
                HZ_BRANCH:  begin rst_v = 5'b01110; en_v = 5'b10001; end
                HZ_LOADUSE: begin rst_v = 5'b00100; en_v = 5'b00011; end
                HZ_FETCH:   begin rst_v = 5'b01000; en_v = 5'b00111; end
                default:    begin rst_v = 5'b00000; en_v = 5'b11111; end
            endcase
        end
    end

    assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = rst_v;
    assign {if_en, id_en, exe_en, mem_en, wb_en}      = en_v;
    assign ctrl_state = state;

    pipe_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .hazard    (hazard),
        .cycle_cnt (cycle_cnt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

endmodule
